// File: rtl/fwd_sel_unit.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
//
// Purpose:
//   Forwarding-select and load-use stall unit sitting between ID and EX.
//   It tracks the destination register of the instructions in EX and MEM and
//   produces registered 2-bit select codes for the EX operand multiplexers:
//     2'b00 = register-file value
//     2'b01 = EX/MEM result
//     2'b10 = MEM/WB result
//   Code 2'b11 is never produced. A load in EX whose destination is read by
//   the instruction in ID raises a one-cycle Stall and inserts a bubble.
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Rst         synchronous active-low reset
//   IdValid     ID holds a real instruction
//   IdRs/IdRt   ID source registers A/B
//   IdRsUsed    operand A is read from a register
//   IdRtUsed    operand B is read from a register
//   IdDst       ID destination register
//   IdRegWrite  ID instruction writes a register
//   IdMemRead   ID instruction is a load
//   Flush       squash the ID instruction
//   SelA/SelB   registered EX operand mux selects
//   Stall       hold PC and IF/ID (combinational from current state)
//   StallCount  saturating count of stall cycles (FWD_STALL_STATS_EN only)
//
// Configuration:
//   FWD_STALL_STATS_EN  when defined, adds the StallCount output and counter.
// -----------------------------------------------------------------------------
module fwd_sel_unit #(
  parameter int REG_BITS  = 5,
  parameter int STAT_BITS = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 IdValid,
  input  logic [REG_BITS-1:0]  IdRs,
  input  logic [REG_BITS-1:0]  IdRt,
  input  logic                 IdRsUsed,
  input  logic                 IdRtUsed,
  input  logic [REG_BITS-1:0]  IdDst,
  input  logic                 IdRegWrite,
  input  logic                 IdMemRead,
  input  logic                 Flush,
  output logic [1:0]           SelA,
  output logic [1:0]           SelB,
  output logic                 Stall
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [STAT_BITS-1:0] StallCount
`endif
);

  localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};

  // EX stage tracking (instruction now in EX)
  logic [REG_BITS-1:0] ex_dst_q, ex_dst_d;
  logic                ex_wr_q,  ex_wr_d;
  logic                ex_ld_q,  ex_ld_d;
  // MEM stage tracking; the load flag is not needed once past EX since a
  // MEM-stage load result is already forwardable from MEM/WB.
  logic [REG_BITS-1:0] mem_dst_q;
  logic                mem_wr_q;
  // Registered selects
  logic [1:0]          sel_a_q, sel_a_d;
  logic [1:0]          sel_b_q, sel_b_d;
  logic                haz_s;
  logic                stall_s;

  // Select for one operand: youngest producer (EX) wins over MEM; $0 is
  // hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic                used,
    input logic [REG_BITS-1:0] src,
    input logic                ex_wr,
    input logic [REG_BITS-1:0] ex_dst,
    input logic                mem_wr,
    input logic [REG_BITS-1:0] mem_dst
  );
    logic [1:0] sel;
    if (!used || (src == REG_ZERO)) begin
      sel = 2'b00;
    end else if (ex_wr && (ex_dst == src)) begin
      sel = 2'b01;
    end else if (mem_wr && (mem_dst == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use hazard detection and stall generation
  always_comb begin
    haz_s = 1'b0;
    if (ex_ld_q && ex_wr_q && (ex_dst_q != REG_ZERO) && IdValid) begin
      haz_s = (IdRsUsed && (IdRs == ex_dst_q)) ||
              (IdRtUsed && (IdRt == ex_dst_q));
    end else begin
      haz_s = 1'b0;
    end
    stall_s = haz_s && !Flush;
  end

  // Next-state for EX tracking and selects; flush or stall inserts a bubble
  always_comb begin
    ex_dst_d = REG_ZERO;
    ex_wr_d  = 1'b0;
    ex_ld_d  = 1'b0;
    sel_a_d  = 2'b00;
    sel_b_d  = 2'b00;
    if (Flush || stall_s) begin
      ex_dst_d = REG_ZERO;
      ex_wr_d  = 1'b0;
      ex_ld_d  = 1'b0;
      sel_a_d  = 2'b00;
      sel_b_d  = 2'b00;
    end else begin
      ex_dst_d = IdDst;
      ex_wr_d  = IdRegWrite && IdValid;
      ex_ld_d  = IdMemRead && IdValid;
      sel_a_d  = fwd_sel(IdRsUsed, IdRs, ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
      sel_b_d  = fwd_sel(IdRtUsed, IdRt, ex_wr_q, ex_dst_q, mem_wr_q, mem_dst_q);
    end
  end

  // Pipeline tracking registers and registered selects
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ex_dst_q  <= REG_ZERO;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_dst_q <= REG_ZERO;
      mem_wr_q  <= 1'b0;
      sel_a_q   <= 2'b00;
      sel_b_q   <= 2'b00;
    end else begin
      ex_dst_q  <= ex_dst_d;
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      mem_dst_q <= ex_dst_q;
      mem_wr_q  <= ex_wr_q;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign SelA  = sel_a_q;
  assign SelB  = sel_b_q;
  assign Stall = stall_s;

`ifdef FWD_STALL_STATS_EN
  logic [STAT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall counter; only flush-surviving stalls are counted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != {STAT_BITS{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STAT_BITS-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_q <= {STAT_BITS{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
module tb_fwd_sel_unit;
  localparam int RB = 5;
  localparam int SB = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          IdValid;
  logic [RB-1:0] IdRs, IdRt, IdDst;
  logic          IdRsUsed, IdRtUsed, IdRegWrite, IdMemRead, Flush;
  logic [1:0]    SelA, SelB;
  logic          Stall;
`ifdef FWD_STALL_STATS_EN
  logic [SB-1:0] StallCount;
`endif

  fwd_sel_unit #(.REG_BITS(RB), .STAT_BITS(SB)) dut (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
    .IdRsUsed(IdRsUsed), .IdRtUsed(IdRtUsed), .IdDst(IdDst),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .Flush(Flush),
    .SelA(SelA), .SelB(SelB), .Stall(Stall)
`ifdef FWD_STALL_STATS_EN
    , .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: the two older in-flight instructions, youngest first.
  typedef struct { bit wr; bit ld; int dst; } rec_t;
  rec_t hist[2];
  logic [1:0] exp_a, exp_b;
  logic       exp_stall, obs_stall;
  int         exp_cnt;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [1:0] model_sel(input bit used, input int src);
    if (!used || src == 0) return 2'd0;
    for (int i = 0; i < 2; i++)
      if (hist[i].wr && hist[i].dst == src) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic issue(input bit v, input int rs, input int rt, input bit rsu,
                       input bit rtu, input int dst, input bit rw, input bit mr,
                       input bit fl);
    IdValid = v; IdRs = RB'(rs); IdRt = RB'(rt); IdRsUsed = rsu; IdRtUsed = rtu;
    IdDst = RB'(dst); IdRegWrite = rw; IdMemRead = mr; Flush = fl;
  endtask

  task automatic nop();
    issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: sample Stall, advance model, return #1 after the edge.
  task automatic tick();
    rec_t nr;
    bit haz;
    @(negedge Clk);
    obs_stall = Stall;
    haz = hist[0].ld && hist[0].wr && hist[0].dst != 0 && IdValid &&
          ((IdRsUsed && int'(IdRs) == hist[0].dst) ||
           (IdRtUsed && int'(IdRt) == hist[0].dst));
    exp_stall = haz && !Flush;
    if (!Rst) begin
      hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
      exp_a = 2'd0; exp_b = 2'd0; exp_cnt = 0;
    end else begin
      if (Flush || exp_stall) begin
        nr = '{0, 0, 0}; exp_a = 2'd0; exp_b = 2'd0;
        if (exp_stall && exp_cnt < (1 << SB) - 1) exp_cnt++;
      end else begin
        exp_a = model_sel(IdRsUsed, int'(IdRs));
        exp_b = model_sel(IdRtUsed, int'(IdRt));
        nr = '{IdRegWrite && IdValid, IdMemRead && IdValid, int'(IdDst)};
      end
      hist[1] = hist[0]; hist[0] = nr;
    end
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; nop(); tick(); Rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", obs_stall); end
    n_tests++; if (SelA !== 2'b00) begin n_fail++; $display("FAIL reset_sela got=%b exp=00", SelA); end
    n_tests++; if (SelB !== 2'b00) begin n_fail++; $display("FAIL reset_selb got=%b exp=00", SelB); end
`ifdef FWD_STALL_STATS_EN
    n_tests++; if (StallCount !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", StallCount); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();   // add $5,$1,$2
    issue(1, 5, 5, 1, 1, 6, 1, 0, 0); tick();   // sub $6,$5,$5
    n_tests++; if (SelA !== 2'b01 || SelA !== exp_a) begin n_fail++; $display("FAIL b2b_sela got=%b exp=01", SelA); end
    n_tests++; if (SelB !== 2'b01 || SelB !== exp_b) begin n_fail++; $display("FAIL b2b_selb got=%b exp=01", SelB); end
  endtask

  task automatic test_distance2();
    do_reset();
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();   // add $5
    issue(1, 1, 2, 1, 1, 7, 1, 0, 0); tick();   // or $7
    issue(1, 5, 7, 1, 1, 8, 1, 0, 0); tick();   // and $8,$5,$7
    n_tests++; if (SelA !== 2'b10) begin n_fail++; $display("FAIL dist2_sela got=%b exp=10", SelA); end
    n_tests++; if (SelB !== 2'b01) begin n_fail++; $display("FAIL dist2_selb got=%b exp=01", SelB); end
    issue(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();   // add $5
    issue(1, 3, 4, 1, 1, 5, 1, 0, 0); tick();   // add $5
    issue(1, 5, 0, 1, 1, 9, 1, 0, 0); tick();   // sub $9,$5,$0
    n_tests++; if (SelA !== 2'b01) begin n_fail++; $display("FAIL youngest_sela got=%b exp=01", SelA); end
    n_tests++; if (SelB !== 2'b00) begin n_fail++; $display("FAIL zero_selb got=%b exp=00", SelB); end
  endtask

  task automatic test_load_use();
    int c0;
    do_reset();
`ifdef FWD_STALL_STATS_EN
    c0 = int'(StallCount);
`else
    c0 = 0;
`endif
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();   // lw $4,0($1)
    n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL lu_pre_stall got=%b exp=0", obs_stall); end
    issue(1, 4, 2, 1, 1, 6, 1, 0, 0); tick();   // add $6,$4,$2
    n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", obs_stall); end
    n_tests++; if (SelA !== 2'b00 || SelB !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_sel got=%b/%b exp=00/00", SelA, SelB); end
    tick();                                     // ID held: retry add
    n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle got=%b exp=0", obs_stall); end
    n_tests++; if (SelA !== 2'b10) begin n_fail++; $display("FAIL lu_sela got=%b exp=10", SelA); end
    n_tests++; if (SelB !== 2'b00) begin n_fail++; $display("FAIL lu_selb got=%b exp=00", SelB); end
`ifdef FWD_STALL_STATS_EN
    n_tests++; if (int'(StallCount) !== c0 + 1) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=%0d", StallCount, c0 + 1); end
`endif
    // Both operands hitting the same load still cost one bubble
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();
    issue(1, 4, 4, 1, 1, 6, 1, 0, 0); tick();
    n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL lu2_stall got=%b exp=1", obs_stall); end
    tick();
    n_tests++; if (obs_stall !== 1'b0 || SelA !== 2'b10 || SelB !== 2'b10) begin
      n_fail++; $display("FAIL lu2_retry got=%b %b/%b exp=0 10/10", obs_stall, SelA, SelB); end
    nop(); tick();
    if (c0 < 0) $display("c0 negative");
  endtask

  task automatic test_flush();
    do_reset();
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();   // lw $4
    issue(1, 4, 4, 1, 1, 6, 1, 0, 1); tick();   // add $6,$4,$4 + Flush
    n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", obs_stall); end
    n_tests++; if (SelA !== 2'b00 || SelB !== 2'b00) begin n_fail++; $display("FAIL flush_sel got=%b/%b exp=00/00", SelA, SelB); end
`ifdef FWD_STALL_STATS_EN
    n_tests++; if (int'(StallCount) !== 0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", StallCount); end
`endif
  endtask

  task automatic test_unused_operand();
    do_reset();
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();   // lw $4
    issue(1, 7, 4, 1, 0, 6, 1, 0, 0); tick();   // addi $6,$7,3 (rt=4 unused)
    n_tests++; if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall got=%b exp=0", obs_stall); end
    n_tests++; if (SelA !== 2'b00 || SelB !== 2'b00) begin n_fail++; $display("FAIL unused_sel got=%b/%b exp=00/00", SelA, SelB); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(1, 1, 0, 1, 0, 4, 1, 1, 0); tick();   // lw $4
    issue(1, 4, 2, 1, 1, 6, 1, 0, 0);
    Rst = 1'b0; tick();                          // reset during stall cycle
    n_tests++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall_before got=%b exp=1", obs_stall); end
    Rst = 1'b1;
    issue(1, 1, 1, 1, 1, 3, 1, 0, 0);           // add $3,$1,$1
    n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall_after got=%b exp=0", Stall); end
    n_tests++; if (SelA !== 2'b00 || SelB !== 2'b00) begin n_fail++; $display("FAIL rms_sel got=%b/%b exp=00/00", SelA, SelB); end
    tick();
    n_tests++; if (SelA !== 2'b00 || SelB !== 2'b00) begin n_fail++; $display("FAIL rms_add_sel got=%b/%b exp=00/00", SelA, SelB); end
`ifdef FWD_STALL_STATS_EN
    n_tests++; if (int'(StallCount) !== 0) begin n_fail++; $display("FAIL rms_cnt got=%0d exp=0", StallCount); end
`endif
  endtask

  task automatic test_random();
    bit prev_stall = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Rst = ($urandom_range(0, 59) != 0);
      if (!(prev_stall && Rst)) begin
        issue($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      end
      tick();
      n_tests++; if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, obs_stall, exp_stall); end
      n_tests++; if (SelA !== exp_a) begin n_fail++; $display("FAIL rnd_sela cyc=%0d got=%b exp=%b", i, SelA, exp_a); end
      n_tests++; if (SelB !== exp_b) begin n_fail++; $display("FAIL rnd_selb cyc=%0d got=%b exp=%b", i, SelB, exp_b); end
      n_tests++; if (prev_stall && obs_stall) begin n_fail++; $display("FAIL rnd_double_stall cyc=%0d got=1 exp=0", i); end
`ifdef FWD_STALL_STATS_EN
      n_tests++; if (int'(StallCount) !== exp_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, StallCount, exp_cnt); end
`endif
      prev_stall = obs_stall && Rst;
    end
    Rst = 1'b1;
  endtask

  initial begin
    hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
    exp_a = 2'd0; exp_b = 2'd0; exp_cnt = 0;
    Rst = 1'b0; nop();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_flush();
    test_unused_operand();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
